// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and slave FSM state type for the register-memory slave.
package ahb_pkg;

   localparam int unsigned HTRANS_W = 2;

   localparam logic [HTRANS_W-1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [HTRANS_W-1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [HTRANS_W-1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [HTRANS_W-1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      ST_READY = 2'd0,
      ST_WAIT  = 2'd1,
      ST_ERR1  = 2'd2,
      ST_ERR2  = 2'd3
   } ahb_state_e;

   // NONSEQ and SEQ are the only transfer types that request a data phase
   function automatic logic htrans_active(input logic [HTRANS_W-1:0] htrans);
      return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
   endfunction

endpackage

// File: rtl/ahb_slave_ram.sv
// Flop-based word memory: one synchronous write port, one combinational read port,
// whole array cleared by the asynchronous reset.
module ahb_slave_ram #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned DEPTH      = 64,
   parameter int unsigned IDX_W      = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [IDX_W-1:0]      waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [IDX_W-1:0]      raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave with word-addressed register memory, programmable wait states
// and a two-cycle ERROR response for out-of-range addresses.
module ahb_slave_mem
   import ahb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned ADDR_WIDTH  = 16,
   parameter int unsigned DEPTH       = 64,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic                  HCLK,
   input  logic                  RESET,
   input  logic                  HSEL,
   input  logic [ADDR_WIDTH-1:0] HADDR,
   input  logic                  HWRITE,
   input  logic [HTRANS_W-1:0]   HTRANS,
   input  logic [DATA_WIDTH-1:0] HWDATA,
   output logic [DATA_WIDTH-1:0] HRDATA,
   output logic                  HREADY,
   output logic                  HRESP
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = 3;

   ahb_state_e            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      addr_q, addr_d;
   logic                  write_q, write_d;
   logic                  pend_q, pend_d;
   logic                  hready_q, hready_d;
   logic                  hresp_q, hresp_d;

   logic                  accept;
   logic                  in_range;
   logic                  complete;
   logic [DATA_WIDTH-1:0] ram_rdata;

   assign accept   = HSEL && htrans_active(HTRANS) && hready_q;
   assign in_range = 32'(HADDR) < DEPTH;
   // An OKAY data phase finishes on the first READY cycle after its address phase
   assign complete = pend_q && (state_q == ST_READY);

   always_ff @(posedge HCLK or negedge RESET) begin
      if (!RESET) begin
         state_q  <= ST_READY;
         cnt_q    <= '0;
         addr_q   <= '0;
         write_q  <= 1'b0;
         pend_q   <= 1'b0;
         hready_q <= 1'b1;
         hresp_q  <= HRESP_OKAY;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         write_q  <= write_d;
         pend_q   <= pend_d;
         hready_q <= hready_d;
         hresp_q  <= hresp_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      write_d = write_q;
      pend_d  = pend_q;

      unique case (state_q)
         ST_READY, ST_ERR2: begin
            state_d = ST_READY;
            pend_d  = 1'b0;
            if (accept) begin
               addr_d  = HADDR[IDX_W-1:0];
               write_d = HWRITE;
               if (in_range) begin
                  pend_d = 1'b1;
                  if (WAIT_STATES != 0) begin
                     state_d = ST_WAIT;
                     cnt_d   = CNT_W'(WAIT_STATES);
                  end
               end else begin
                  state_d = ST_ERR1;
               end
            end
         end
         ST_WAIT: begin
            cnt_d = CNT_W'(cnt_q - CNT_W'(1));
            if (cnt_q <= CNT_W'(1)) begin
               state_d = ST_READY;
            end
         end
         ST_ERR1: begin
            state_d = ST_ERR2;
         end
         default: begin
            state_d = ST_READY;
         end
      endcase

      hready_d = (state_d == ST_READY) || (state_d == ST_ERR2);
      hresp_d  = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
   end

   ahb_slave_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .IDX_W      (IDX_W)
   ) u_ram (
      .clk   (HCLK),
      .rst_n (RESET),
      .we    (complete && write_q),
      .waddr (addr_q),
      .wdata (HWDATA),
      .raddr (addr_q),
      .rdata (ram_rdata)
   );

   assign HRDATA = (complete && !write_q) ? ram_rdata : '0;
   assign HREADY = hready_q;
   assign HRESP  = hresp_q;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: cycle table on a 1-wait-state instance,
// reset-during-wait sequence, and a pipelined burst on a 0-wait-state instance.
module tb_ahb_slave_mem;
   import ahb_pkg::*;

   typedef struct {
      logic        hsel;
      logic [1:0]  htrans;
      logic        hwrite;
      logic [15:0] haddr;
      logic [15:0] hwdata;
      logic        e_ready;
      logic        e_resp;
      logic [15:0] e_rdata;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   logic        s1_hsel, s1_hwrite, s1_hready, s1_hresp;
   logic [1:0]  s1_htrans;
   logic [15:0] s1_haddr, s1_hwdata, s1_hrdata;

   logic        s0_hsel, s0_hwrite, s0_hready, s0_hresp;
   logic [1:0]  s0_htrans;
   logic [15:0] s0_haddr, s0_hwdata, s0_hrdata;

   int   n_tests = 0;
   int   n_fail  = 0;
   vec_t tbl[$];

   always #5 clk = ~clk;

   ahb_slave_mem #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(64), .WAIT_STATES(1)) dut1 (
      .HCLK(clk), .RESET(rst_n), .HSEL(s1_hsel), .HADDR(s1_haddr), .HWRITE(s1_hwrite),
      .HTRANS(s1_htrans), .HWDATA(s1_hwdata), .HRDATA(s1_hrdata), .HREADY(s1_hready),
      .HRESP(s1_hresp)
   );

   ahb_slave_mem #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(64), .WAIT_STATES(0)) dut0 (
      .HCLK(clk), .RESET(rst_n), .HSEL(s0_hsel), .HADDR(s0_haddr), .HWRITE(s0_hwrite),
      .HTRANS(s0_htrans), .HWDATA(s0_hwdata), .HRDATA(s0_hrdata), .HREADY(s0_hready),
      .HRESP(s0_hresp)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic hsel, input logic [1:0] htrans, input logic hwrite,
                               input logic [15:0] haddr, input logic [15:0] hwdata,
                               input logic e_ready, input logic e_resp, input logic [15:0] e_rdata);
      vec_t v;
      v.hsel = hsel; v.htrans = htrans; v.hwrite = hwrite; v.haddr = haddr; v.hwdata = hwdata;
      v.e_ready = e_ready; v.e_resp = e_resp; v.e_rdata = e_rdata;
      return v;
   endfunction

   // One bus cycle on dut1: drive just after the edge, compare at the falling edge
   task automatic step1(input vec_t v, input string tag);
      s1_hsel = v.hsel; s1_htrans = v.htrans; s1_hwrite = v.hwrite;
      s1_haddr = v.haddr; s1_hwdata = v.hwdata;
      @(negedge clk);
      check({tag, ".hready"}, 32'(s1_hready), 32'(v.e_ready));
      check({tag, ".hresp"},  32'(s1_hresp),  32'(v.e_resp));
      check({tag, ".hrdata"}, 32'(s1_hrdata), 32'(v.e_rdata));
      @(posedge clk);
      #1;
   endtask

   initial begin
      s1_hsel = 0; s1_htrans = HTRANS_IDLE; s1_hwrite = 0; s1_haddr = 0; s1_hwdata = 0;
      s0_hsel = 0; s0_htrans = HTRANS_IDLE; s0_hwrite = 0; s0_haddr = 0; s0_hwdata = 0;

      // {hsel, htrans, hwrite, haddr, hwdata} -> {hready, hresp, hrdata}
      tbl.push_back(mk(1, HTRANS_NONSEQ, 1, 16'd20,  16'h0000, 1, 0, 16'h0000));
      tbl.push_back(mk(1, HTRANS_IDLE,   0, 16'd0,   16'h000C, 0, 0, 16'h0000));
      tbl.push_back(mk(1, HTRANS_NONSEQ, 0, 16'd20,  16'h000C, 1, 0, 16'h0000));
      tbl.push_back(mk(0, HTRANS_IDLE,   0, 16'd0,   16'h0000, 0, 0, 16'h0000));
      tbl.push_back(mk(1, HTRANS_NONSEQ, 1, 16'd1,   16'h0000, 1, 0, 16'h000C));
      tbl.push_back(mk(1, HTRANS_IDLE,   0, 16'd0,   16'h0059, 0, 0, 16'h0000));
      tbl.push_back(mk(1, HTRANS_NONSEQ, 0, 16'd1,   16'h0059, 1, 0, 16'h0000));
      tbl.push_back(mk(0, HTRANS_IDLE,   0, 16'd0,   16'h0000, 0, 0, 16'h0000));
      tbl.push_back(mk(1, HTRANS_NONSEQ, 0, 16'd64,  16'h0000, 1, 0, 16'h0059));
      tbl.push_back(mk(1, HTRANS_IDLE,   0, 16'd0,   16'h0000, 0, 1, 16'h0000));
      tbl.push_back(mk(1, HTRANS_NONSEQ, 1, 16'd100, 16'h0000, 1, 1, 16'h0000));
      tbl.push_back(mk(1, HTRANS_IDLE,   0, 16'd0,   16'hBEEF, 0, 1, 16'h0000));
      tbl.push_back(mk(1, HTRANS_IDLE,   1, 16'd20,  16'hBEEF, 1, 1, 16'h0000));
      tbl.push_back(mk(1, HTRANS_BUSY,   1, 16'd20,  16'hDEAD, 1, 0, 16'h0000));
      tbl.push_back(mk(0, HTRANS_NONSEQ, 1, 16'd20,  16'hDEAD, 1, 0, 16'h0000));
      tbl.push_back(mk(1, HTRANS_NONSEQ, 0, 16'd20,  16'hDEAD, 1, 0, 16'h0000));
      tbl.push_back(mk(0, HTRANS_IDLE,   0, 16'd0,   16'h0000, 0, 0, 16'h0000));
      tbl.push_back(mk(1, HTRANS_SEQ,    0, 16'd1,   16'h0000, 1, 0, 16'h000C));
      tbl.push_back(mk(0, HTRANS_IDLE,   0, 16'd0,   16'h0000, 0, 0, 16'h0000));
      tbl.push_back(mk(1, HTRANS_NONSEQ, 0, 16'd36,  16'h0000, 1, 0, 16'h0059));
      tbl.push_back(mk(0, HTRANS_IDLE,   0, 16'd0,   16'h0000, 0, 0, 16'h0000));
      tbl.push_back(mk(1, HTRANS_NONSEQ, 1, 16'd63,  16'h0000, 1, 0, 16'h0000));
      tbl.push_back(mk(0, HTRANS_IDLE,   0, 16'd0,   16'hA5A5, 0, 0, 16'h0000));
      tbl.push_back(mk(1, HTRANS_NONSEQ, 0, 16'd63,  16'hA5A5, 1, 0, 16'h0000));
      tbl.push_back(mk(0, HTRANS_IDLE,   0, 16'd0,   16'h0000, 0, 0, 16'h0000));
      tbl.push_back(mk(0, HTRANS_IDLE,   0, 16'd0,   16'h0000, 1, 0, 16'hA5A5));
      tbl.push_back(mk(0, HTRANS_IDLE,   0, 16'd0,   16'h0000, 1, 0, 16'h0000));

      #12 rst_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (tbl[i]) step1(tbl[i], $sformatf("row%0d", i));

      // Write 5, then reset in the middle of the wait state of write 6
      step1(mk(1, HTRANS_NONSEQ, 1, 16'd5, 16'h0000, 1, 0, 16'h0000), "w5.addr");
      step1(mk(1, HTRANS_IDLE,   0, 16'd0, 16'h1234, 0, 0, 16'h0000), "w5.wait");
      step1(mk(1, HTRANS_NONSEQ, 1, 16'd6, 16'h1234, 1, 0, 16'h0000), "w6.addr");
      s1_hsel = 1; s1_htrans = HTRANS_IDLE; s1_hwrite = 0; s1_haddr = 0; s1_hwdata = 16'hFFFF;
      #1;
      check("w6.wait.hready", 32'(s1_hready), 32'd0);
      #1 rst_n = 1'b0;
      #1;
      check("rst.hready", 32'(s1_hready), 32'd1);
      check("rst.hresp",  32'(s1_hresp),  32'd0);
      check("rst.hrdata", 32'(s1_hrdata), 32'd0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      step1(mk(1, HTRANS_NONSEQ, 0, 16'd5, 16'h0000, 1, 0, 16'h0000), "r5.addr");
      step1(mk(0, HTRANS_IDLE,   0, 16'd0, 16'h0000, 0, 0, 16'h0000), "r5.wait");
      step1(mk(1, HTRANS_NONSEQ, 0, 16'd6, 16'h0000, 1, 0, 16'h0000), "r5.data");
      step1(mk(0, HTRANS_IDLE,   0, 16'd0, 16'h0000, 0, 0, 16'h0000), "r6.wait");
      step1(mk(0, HTRANS_IDLE,   0, 16'd0, 16'h0000, 1, 0, 16'h0000), "r6.data");

      // Zero-wait instance: eight pipelined writes 10..17 then eight pipelined reads
      for (int c = 0; c < 17; c++) begin
         logic [15:0] exp_rd;
         s0_hsel   = (c < 16);
         s0_htrans = (c < 16) ? HTRANS_NONSEQ : HTRANS_IDLE;
         s0_hwrite = (c < 8);
         s0_haddr  = (c < 8) ? 16'(10 + c) : 16'(10 + c - 8);
         s0_hwdata = (c >= 1 && c <= 8) ? 16'(16'h1000 + (c - 1) * 16'h0111) : 16'h0000;
         exp_rd    = (c >= 9) ? 16'(16'h1000 + (c - 9) * 16'h0111) : 16'h0000;
         @(negedge clk);
         check($sformatf("ws0.c%0d.hready", c), 32'(s0_hready), 32'd1);
         check($sformatf("ws0.c%0d.hrdata", c), 32'(s0_hrdata), 32'(exp_rd));
         @(posedge clk);
         #1;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
